// File: rtl/npc_lsu_if.sv
// Request, response and data-memory signals of the NPC load/store unit.
// slave = the LSU itself; master = its EXU/WBU/memory environment.
interface npc_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [31:0] in_addr;
    logic [63:0] in_wdata;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic        out_err;
    logic [31:0] mem_raddr;
    logic [63:0] mem_rdata;
    logic [31:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;

    modport slave (
        input  in_valid, in_wen, in_addr, in_wdata, in_size, in_unsigned,
        input  out_ready, mem_rdata,
        output in_ready, out_valid, out_rdata, out_err,
        output mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );

    modport master (
        output in_valid, in_wen, in_addr, in_wdata, in_size, in_unsigned,
        output out_ready, mem_rdata,
        input  in_ready, out_valid, out_rdata, out_err,
        input  mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/npc_lsu.sv
// NPC load/store unit: one access in flight, IDLE -> ACCESS (1+WAIT_CYCLES) -> RESP; all outputs registered.
// Latency handshake->out_valid is 2+WAIT_CYCLES edges; RESP holds until out_ready. Optional LSU_MISALIGN_CHECK_EN faults unaligned requests.
module npc_lsu #(
    parameter logic [31:0] RESET_ADDR  = 32'h8000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic     clk,
    input  logic     rst,
    npc_lsu_if.slave bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_wen, w_wen_nxt;
    logic [1:0]  r_size, w_size_nxt;
    logic        r_uns, w_uns_nxt;
    logic [2:0]  r_off, w_off_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [63:0] r_wdata, w_wdata_nxt;
    logic [7:0]  r_wmask, w_wmask_nxt;
    logic [63:0] r_rdata, w_rdata_nxt;
    logic        r_err, w_err_nxt;

    logic [7:0]  w_size_mask;
    logic        w_misalign;
    logic [63:0] w_shifted;
    logic [63:0] w_load;

    always_comb begin
        case (bus.in_size)
            2'd0:    w_size_mask = 8'h01;
            2'd1:    w_size_mask = 8'h03;
            2'd2:    w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        case (bus.in_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = bus.in_addr[0];
            2'd2:    w_misalign = |bus.in_addr[1:0];
            default: w_misalign = |bus.in_addr[2:0];
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Lanes past byte 7 shift in as zero, so a straddling load sees only its in-word bytes.
    assign w_shifted = bus.mem_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_size)
            2'd0:    w_load = {{56{~r_uns & w_shifted[7]}},  w_shifted[7:0]};
            2'd1:    w_load = {{48{~r_uns & w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    w_load = {{32{~r_uns & w_shifted[31]}}, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wen_nxt   = r_wen;
        w_size_nxt  = r_size;
        w_uns_nxt   = r_uns;
        w_off_nxt   = r_off;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_wmask_nxt = r_wmask;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (w_misalign) begin
                        w_state_nxt = ST_RESP;
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = '0;
                        w_wmask_nxt = '0;
                    end else begin
                        w_state_nxt = ST_ACCESS;
                        w_wen_nxt   = bus.in_wen;
                        w_size_nxt  = bus.in_size;
                        w_uns_nxt   = bus.in_unsigned;
                        w_off_nxt   = bus.in_addr[2:0];
                        w_cnt_nxt   = 4'(WAIT_CYCLES);
                        w_addr_nxt  = {bus.in_addr[31:3], 3'b000};
                        w_wdata_nxt = bus.in_wdata << {bus.in_addr[2:0], 3'b000};
                        w_wmask_nxt = bus.in_wen ? (w_size_mask << bus.in_addr[2:0]) : 8'h00;
                        w_err_nxt   = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                // The write strobe is a single-cycle pulse on the first ACCESS cycle.
                w_wmask_nxt = '0;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                    w_rdata_nxt = r_wen ? 64'd0 : w_load;
                    w_addr_nxt  = RESET_ADDR;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wen   <= 1'b0;
            r_size  <= 2'd0;
            r_uns   <= 1'b0;
            r_off   <= 3'd0;
            r_cnt   <= 4'd0;
            r_addr  <= RESET_ADDR;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wen   <= w_wen_nxt;
            r_size  <= w_size_nxt;
            r_uns   <= w_uns_nxt;
            r_off   <= w_off_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_wmask <= w_wmask_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_RESP);
    assign bus.out_rdata = r_rdata;
    assign bus.out_err   = r_err;
    assign bus.mem_raddr = r_addr;
    assign bus.mem_waddr = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_wmask = r_wmask;

endmodule

// File: tb/tb_npc_lsu.sv
// Bench for npc_lsu: three instances (WAIT_CYCLES 0/2/3), a timeline model checked every cycle, plus directed literal checks.
module tb_npc_lsu;
    localparam logic [31:0] RST_ADDR = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid[3];
    logic        in_wen[3];
    logic [31:0] in_addr[3];
    logic [63:0] in_wdata[3];
    logic [1:0]  in_size[3];
    logic        in_uns[3];
    logic        out_ready[3];
    logic [63:0] mem_rdata[3];
    logic        in_ready[3];
    logic        out_valid[3];
    logic [63:0] out_rdata[3];
    logic        out_err[3];
    logic [31:0] mem_raddr[3];
    logic [31:0] mem_waddr[3];
    logic [63:0] mem_wdata[3];
    logic [7:0]  mem_wmask[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        npc_lsu_if bus ();
        assign bus.in_valid    = in_valid[g];
        assign bus.in_wen      = in_wen[g];
        assign bus.in_addr     = in_addr[g];
        assign bus.in_wdata    = in_wdata[g];
        assign bus.in_size     = in_size[g];
        assign bus.in_unsigned = in_uns[g];
        assign bus.out_ready   = out_ready[g];
        assign bus.mem_rdata   = mem_rdata[g];
        assign in_ready[g]     = bus.in_ready;
        assign out_valid[g]    = bus.out_valid;
        assign out_rdata[g]    = bus.out_rdata;
        assign out_err[g]      = bus.out_err;
        assign mem_raddr[g]    = bus.mem_raddr;
        assign mem_waddr[g]    = bus.mem_waddr;
        assign mem_wdata[g]    = bus.mem_wdata;
        assign mem_wmask[g]    = bus.mem_wmask;
        npc_lsu #(.RESET_ADDR(RST_ADDR), .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int wcyc[3] = '{0, 2, 3};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Byte-level reference: gather the accessed bytes, then extend.
    function automatic logic [63:0] f_load(logic [63:0] d, logic [2:0] off, logic [1:0] sz, bit uns);
        logic [63:0] r;
        int n;
        r = '0;
        n = 1 << sz;
        for (int i = 0; i < n; i++)
            if (int'(off) + i < 8) r[8*i +: 8] = d[8*(int'(off) + i) +: 8];
        if (!uns && n < 8 && r[8*n-1])
            for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [7:0] f_mask(logic [2:0] off, logic [1:0] sz);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < (1 << sz); i++)
            if (int'(off) + i < 8) m[int'(off) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] f_wdata(logic [63:0] d, logic [2:0] off);
        logic [63:0] w;
        w = '0;
        for (int b = 0; b < 8; b++)
            if (b >= int'(off)) w[8*b +: 8] = d[8*(b - int'(off)) +: 8];
        return w;
    endfunction

    function automatic bit f_mis(logic [31:0] a, logic [1:0] sz);
`ifdef LSU_MISALIGN_CHECK_EN
        return (int'(a[2:0]) % (1 << sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Model: per instance, one pending request with the cycle it was accepted in.
    bit          pend[3];
    int          hs[3];
    int          rsp_at[3];
    bit          m_st[3];
    bit          m_mis[3];
    logic [7:0]  e_mask[3];
    logic [31:0] e_addr[3];
    logic [63:0] e_wdata[3];
    logic [63:0] e_rdata[3];
    logic [2:0]  m_off[3];
    logic [1:0]  m_sz[3];
    bit          m_uns[3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                pend[k] = 1'b0;
            end else if (pend[k]) begin
                if (!m_st[k] && !m_mis[k] && cyc + 1 == rsp_at[k])
                    e_rdata[k] = f_load(mem_rdata[k], m_off[k], m_sz[k], m_uns[k]);
                if (cyc >= rsp_at[k] && out_ready[k]) pend[k] = 1'b0;
            end else if (in_valid[k]) begin
                pend[k]    = 1'b1;
                hs[k]      = cyc + 1;
                m_st[k]    = in_wen[k];
                m_mis[k]   = f_mis(in_addr[k], in_size[k]);
                m_off[k]   = in_addr[k][2:0];
                m_sz[k]    = in_size[k];
                m_uns[k]   = in_uns[k];
                e_addr[k]  = {in_addr[k][31:3], 3'b000};
                e_mask[k]  = in_wen[k] ? f_mask(in_addr[k][2:0], in_size[k]) : 8'h00;
                e_wdata[k] = f_wdata(in_wdata[k], in_addr[k][2:0]);
                e_rdata[k] = '0;
                rsp_at[k]  = m_mis[k] ? hs[k] : hs[k] + wcyc[k] + 1;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                bit acc, vld, wr;
                acc = pend[k] && !m_mis[k] && cyc >= hs[k] && cyc <= hs[k] + wcyc[k];
                vld = pend[k] && cyc >= rsp_at[k];
                wr  = pend[k] && m_st[k] && !m_mis[k] && cyc == hs[k];
                chk($sformatf("in_ready[%0d]", k), 64'(in_ready[k]), 64'(!pend[k]));
                chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(vld));
                chk($sformatf("wmask[%0d]", k), 64'(mem_wmask[k]), 64'(wr ? e_mask[k] : 8'h00));
                chk($sformatf("raddr[%0d]", k), 64'(mem_raddr[k]), 64'(acc ? e_addr[k] : RST_ADDR));
                chk($sformatf("waddr[%0d]", k), 64'(mem_waddr[k]), 64'(acc ? e_addr[k] : RST_ADDR));
                if (wr) chk($sformatf("wdata[%0d]", k), mem_wdata[k], e_wdata[k]);
                if (vld) begin
                    chk($sformatf("rdata[%0d]", k), out_rdata[k], (m_st[k] || m_mis[k]) ? 64'd0 : e_rdata[k]);
                    chk($sformatf("err[%0d]", k), 64'(out_err[k]), 64'(m_mis[k]));
                end
            end
        end
    end

    // Issue one request, wait (bounded) for the response, hold it for 'hold' cycles, then accept.
    task automatic req(input int k, input bit wen, input logic [31:0] a, input logic [63:0] wd,
                       input logic [1:0] sz, input bit u, input logic [63:0] md, input int hold,
                       output logic [63:0] rd, output logic er, output int lat,
                       output logic [7:0] wm, output logic [31:0] wa, output logic [63:0] wdo);
        int n0;
        @(negedge clk);
        mem_rdata[k] = md;
        in_wen[k]    = wen;
        in_addr[k]   = a;
        in_wdata[k]  = wd;
        in_size[k]   = sz;
        in_uns[k]    = u;
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b0;
        @(negedge clk);
        in_valid[k] = 1'b0;
        n0  = cyc;
        wm  = mem_wmask[k];
        wa  = mem_waddr[k];
        wdo = mem_wdata[k];
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid[k]) begin
                lat = cyc - n0;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            chk("resp_timeout", 64'd0, 64'd1);
            rd = 'x;
            er = 1'bx;
        end else begin
            rd = out_rdata[k];
            er = out_err[k];
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", 64'(out_valid[k]), 64'd1);
                chk("hold_rdata", out_rdata[k], rd);
                chk("hold_in_ready", 64'(in_ready[k]), 64'd0);
            end
            out_ready[k] = 1'b1;
            @(negedge clk);
            out_ready[k] = 1'b0;
            chk("ready_after_accept", 64'(in_ready[k]), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rd, wdo;
        logic        er;
        int          lat;
        logic [7:0]  wm;
        logic [31:0] wa;

        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_wen[k] = 1'b0; in_addr[k] = '0; in_wdata[k] = '0;
            in_size[k] = '0; in_uns[k] = 1'b0; out_ready[k] = 1'b0; mem_rdata[k] = '0;
        end
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        repeat (10) begin
            @(negedge clk);
            chk("idle_in_ready", 64'(in_ready[0]), 64'd1);
            chk("idle_out_valid", 64'(out_valid[0]), 64'd0);
            chk("idle_wmask", 64'(mem_wmask[0]), 64'd0);
            chk("idle_raddr", 64'(mem_raddr[0]), 64'h8000_0000);
        end

        req(0, 1, 32'h8000_0013, 64'hAB, 2'd0, 0, 64'd0, 0, rd, er, lat, wm, wa, wdo);
        chk("stb_wmask", 64'(wm), 64'h08);
        chk("stb_waddr", 64'(wa), 64'h8000_0010);
        chk("stb_wdata", wdo, 64'hAB00_0000);
        chk("stb_lat", 64'(lat), 64'd1);
        chk("stb_rdata", rd, 64'd0);

        req(0, 0, 32'h8000_0014, 64'd0, 2'd2, 0, 64'h8765_4321_0000_0000, 0, rd, er, lat, wm, wa, wdo);
        chk("lw_signed", rd, 64'hFFFF_FFFF_8765_4321);
        chk("lw_wmask", 64'(wm), 64'd0);
        req(0, 0, 32'h8000_0014, 64'd0, 2'd2, 1, 64'h8765_4321_0000_0000, 0, rd, er, lat, wm, wa, wdo);
        chk("lw_unsigned", rd, 64'h0000_0000_8765_4321);

        req(0, 0, 32'h8000_0007, 64'd0, 2'd0, 0, 64'h80FF_FFFF_FFFF_FF00, 0, rd, er, lat, wm, wa, wdo);
        chk("lb_lane7", rd, 64'hFFFF_FFFF_FFFF_FF80);
        req(0, 1, 32'h8000_0026, 64'hBEEF, 2'd1, 0, 64'd0, 0, rd, er, lat, wm, wa, wdo);
        chk("sh_wmask", 64'(wm), 64'hC0);
        chk("sh_wdata", wdo, 64'hBEEF_0000_0000_0000);

        req(2, 0, 32'h8000_0008, 64'd0, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 5, rd, er, lat, wm, wa, wdo);
        chk("ld_w3_lat", 64'(lat), 64'd4);
        chk("ld_w3_rdata", rd, 64'h0123_4567_89AB_CDEF);
        req(2, 1, 32'h8000_0020, 64'h1122_3344_5566_7788, 2'd3, 0, 64'd0, 1, rd, er, lat, wm, wa, wdo);
        chk("sd_w3_wmask", 64'(wm), 64'hFF);
        chk("sd_w3_lat", 64'(lat), 64'd4);

        req(0, 0, 32'h8000_0001, 64'd0, 2'd1, 0, 64'h1122_3344_5597_A688, 0, rd, er, lat, wm, wa, wdo);
        chk("mis_wmask", 64'(wm), 64'd0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("mis_lat", 64'(lat), 64'd0);
        chk("mis_err", 64'(er), 64'd1);
        chk("mis_rdata", rd, 64'd0);
`else
        chk("mis_lat", 64'(lat), 64'd1);
        chk("mis_err", 64'(er), 64'd0);
        chk("mis_rdata", rd, 64'hFFFF_FFFF_FFFF_97A6);
`endif

        // Reset during the first ACCESS cycle of a store on the WAIT_CYCLES=2 instance.
        @(negedge clk);
        in_wen[1] = 1'b1; in_addr[1] = 32'h8000_0030; in_wdata[1] = 64'h55;
        in_size[1] = 2'd0; in_uns[1] = 1'b0; in_valid[1] = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0;
        chk("rst_pre_wmask", 64'(mem_wmask[1]), 64'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready[1]), 64'd1);
        chk("rst_out_valid", 64'(out_valid[1]), 64'd0);
        chk("rst_wmask", 64'(mem_wmask[1]), 64'd0);
        chk("rst_raddr", 64'(mem_raddr[1]), 64'h8000_0000);
        chk("rst_wdata", mem_wdata[1], 64'd0);
        chk("rst_rdata", out_rdata[1], 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_no_valid", 64'(out_valid[1]), 64'd0);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
